// File: rtl/sync_debounce_if.sv
// Signal bundle for sync_debounce: raw inputs in, conditioned levels and edge pulses out.
// The master side drives the raw pins; the slave side is the conditioner.
interface sync_debounce_if #(
    parameter int unsigned DATA_WIDTH = 1
);

    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] rise_pulse;
    logic [DATA_WIDTH-1:0] fall_pulse;
    logic                  any_change;

    modport master (
        output data_in,
        input  data_out,
        input  rise_pulse,
        input  fall_pulse,
        input  any_change
    );

    modport slave (
        input  data_in,
        output data_out,
        output rise_pulse,
        output fall_pulse,
        output any_change
    );

endinterface

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: per-channel synchronizer chain, debounce counter,
// and registered single-cycle rise/fall pulses on each debounced update.
module sync_debounce #(
    parameter int unsigned           DATA_WIDTH      = 1,
    parameter int unsigned           SYNC_STAGES     = 2,
    parameter int unsigned           DEBOUNCE_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0
) (
    input logic           clk_i,
    input logic           reset_i,
    sync_debounce_if.slave bus
);

    localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                  data_q, data_d;
    logic [DATA_WIDTH-1:0]                  rise_q, rise_d;
    logic [DATA_WIDTH-1:0]                  fall_q, fall_d;
    logic [DATA_WIDTH-1:0]                  synced;

    // Pure shift chain, no logic between stages.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.data_in};
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (synced[i] == data_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                data_d[i] = synced[i];
                cnt_d[i]  = '0;
                rise_d[i] = synced[i];
                fall_d[i] = ~synced[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q  <= '0;
            data_q <= RESET_VALUE;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce (4 channels, 2 sync stages, 4-cycle debounce):
// a per-edge vector table followed by hand-written reset-mid-count and bounce sequences.
module tb_sync_debounce;

    typedef struct {
        logic       rst;
        logic [3:0] din;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    sync_debounce_if #(.DATA_WIDTH(4)) bus ();

    sync_debounce #(
        .DATA_WIDTH     (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_VALUE    (4'h0)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int n, input logic rst, input logic [3:0] din,
                       input logic [3:0] out, input logic [3:0] rise, input logic [3:0] fall);
        vec_t v;
        v.rst  = rst;
        v.din  = din;
        v.out  = out;
        v.rise = rise;
        v.fall = fall;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic step(input logic rst, input logic [3:0] din);
        @(negedge clk);
        reset       = rst;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] out,
                             input logic [3:0] rise, input logic [3:0] fall);
        logic [3:0] any_exp;
        any_exp = {3'b000, |(rise | fall)};
        check({tag, " data_out"}, bus.data_out, out);
        check({tag, " rise_pulse"}, bus.rise_pulse, rise);
        check({tag, " fall_pulse"}, bus.fall_pulse, fall);
        check({tag, " any_change"}, {3'b000, bus.any_change}, any_exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.data_in = 4'h0;

        // Reset with inputs high; update lands on the 6th post-release edge.
        add(3, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(5, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0);
        add(3, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
        // Glitch of 3 cycles on channel 0 is rejected.
        add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(3, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(8, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Clean step on channel 2.
        add(5, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'h4, 4'h4, 4'h4, 4'h0);
        add(4, 1'b0, 4'h4, 4'h4, 4'h0, 4'h0);
        // Reach 4'b1000, then swap to 4'b0010: rise and fall in one cycle.
        add(1, 1'b1, 4'h8, 4'h0, 4'h0, 4'h0);
        add(5, 1'b0, 4'h8, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'h8, 4'h8, 4'h8, 4'h0);
        add(5, 1'b0, 4'h2, 4'h8, 4'h0, 4'h0);
        add(1, 1'b0, 4'h2, 4'h2, 4'h2, 4'h8);
        add(3, 1'b0, 4'h2, 4'h2, 4'h0, 4'h0);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].din);
            check_all($sformatf("vec%0d", n), vecs[n].out, vecs[n].rise, vecs[n].fall);
        end

        // Reset pulsed at edge k+3 discards the partial count on channel 1.
        step(1'b1, 4'h0);
        check_all("mid_rst pre", 4'h0, 4'h0, 4'h0);
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 4'h2);
            check_all($sformatf("mid_rst count%0d", j), 4'h0, 4'h0, 4'h0);
        end
        step(1'b1, 4'h2);
        check_all("mid_rst in_reset", 4'h0, 4'h0, 4'h0);
        for (int j = 1; j <= 10; j++) begin
            step(1'b0, 4'h2);
            check_all($sformatf("mid_rst post%0d", j), (j >= 6) ? 4'h2 : 4'h0,
                      (j == 6) ? 4'h2 : 4'h0, 4'h0);
        end

        // Channel 3 bounces every 2 cycles for 20 cycles, then settles high.
        step(1'b1, 4'h0);
        check_all("bounce pre", 4'h0, 4'h0, 4'h0);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, (((c / 2) % 2) == 0) ? 4'h8 : 4'h0);
            check_all($sformatf("bounce burst%0d", c), 4'h0, 4'h0, 4'h0);
        end
        for (int j = 1; j <= 10; j++) begin
            step(1'b0, 4'h8);
            check_all($sformatf("bounce hold%0d", j), (j >= 6) ? 4'h8 : 4'h0,
                      (j == 6) ? 4'h8 : 4'h0, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
